// File: rtl/timekeep_pkg.sv
// ---------------------------------------------------------------------------
// timekeep_pkg
// Shared definitions for the timekeeping controller:
//   - set_field encodings and the controller state enum built on them
//   - packed-BCD limit constants for seconds/minutes (8'h59) and hours (8'h23)
//   - bcd2_next(): next value of a two-digit BCD count with a wrap limit
// ---------------------------------------------------------------------------
package timekeep_pkg;

  localparam logic [1:0] FIELD_RUN      = 2'b00;
  localparam logic [1:0] FIELD_SET_HOUR = 2'b01;
  localparam logic [1:0] FIELD_SET_MIN  = 2'b10;

  // State values double as the set_field encoding, so the output is the
  // state register itself.
  typedef enum logic [1:0] {
    ST_RUN      = FIELD_RUN,
    ST_SET_HOUR = FIELD_SET_HOUR,
    ST_SET_MIN  = FIELD_SET_MIN
  } state_e;

  localparam logic [7:0] BCD_MAX_MIN_SEC = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR    = 8'h23;

  // Wraps to 00 at maxVal; otherwise a low digit of 9 rolls into the high digit.
  function automatic logic [7:0] bcd2_next(input logic [7:0] value,
                                           input logic [7:0] maxVal);
    logic [7:0] result;
    if (value == maxVal) begin
      result = 8'h00;
    end else if (value[3:0] == 4'h9) begin
      result = {value[7:4] + 4'h1, 4'h0};
    end else begin
      result = {value[7:4], value[3:0] + 4'h1};
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// ---------------------------------------------------------------------------
// bcd2_counter
// Two-digit packed-BCD counter that wraps from MAX_VAL to 8'h00.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low clear
//   i_clr    in   synchronous clear to 8'h00 (wins over i_inc)
//   i_inc    in   increment enable
//   o_value  out  current count, packed BCD
//   o_carry  out  high in the cycle an increment wraps MAX_VAL to 8'h00
// ---------------------------------------------------------------------------
module bcd2_counter
  import timekeep_pkg::*;
#(
  parameter logic [7:0] MAX_VAL = BCD_MAX_MIN_SEC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_value,
  output logic       o_carry
);

  logic [7:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 8'h00;
    end else if (i_clr) begin
      r_value <= 8'h00;
    end else if (i_inc) begin
      r_value <= bcd2_next(r_value, MAX_VAL);
    end
  end

  assign o_value = r_value;
  assign o_carry = i_inc && !i_clr && (r_value == MAX_VAL);

endmodule

// File: rtl/timekeep_ctrl.sv
// ---------------------------------------------------------------------------
// timekeep_ctrl
// 24 h BCD clock with a two-field set mode (hour, then minute), set-mode
// timeout, blink phase for the field being set and an hourly chime.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   tick_1hz   in   single-cycle 1 Hz enable
//   mode_btn   in   single-cycle pulse: RUN -> SET_HOUR -> SET_MIN -> RUN
//   inc_btn    in   single-cycle pulse: increments the field being set
//   hour       out  packed BCD 8'h00..8'h23
//   minute     out  packed BCD 8'h00..8'h59
//   second     out  packed BCD 8'h00..8'h59
//   set_field  out  00 RUN, 01 SET_HOUR, 10 SET_MIN
//   blink      out  blank phase of the field being set
//   chime      out  one-cycle pulse on each hour rollover
// ---------------------------------------------------------------------------
module timekeep_ctrl
  import timekeep_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [1:0] set_field,
  output logic       blink,
  output logic       chime
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_e          r_state;
  state_e          w_nextState;
  logic [TW-1:0]   r_timeout;
  logic            r_blink;
  logic            r_chime;

  logic            w_incEvt;
  logic            w_timeoutHit;
  logic            w_secClr;
  logic            w_secInc;
  logic            w_minInc;
  logic            w_hourInc;
  logic            w_secCarry;
  logic            w_minCarry;
  logic            w_unusedHourCarry;

  // mode_btn wins a same-cycle collision, so inc_btn is dropped.
  assign w_incEvt = inc_btn && !mode_btn;

  // The timeout fires on the tick that would bring the counter to the limit,
  // so the return to RUN is visible the cycle after that tick. Any button
  // press in the same cycle restarts the count instead.
  assign w_timeoutHit = (r_state != ST_RUN) && tick_1hz && !mode_btn && !inc_btn &&
                        (r_timeout == TW'(TIMEOUT_TICKS - 1));

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_RUN:      if (mode_btn) w_nextState = ST_SET_HOUR;
      ST_SET_HOUR: begin
        if (mode_btn)          w_nextState = ST_SET_MIN;
        else if (w_timeoutHit) w_nextState = ST_RUN;
      end
      ST_SET_MIN: begin
        if (mode_btn || w_timeoutHit) w_nextState = ST_RUN;
      end
      default:     w_nextState = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Timeout counter is only meaningful while staying in a set state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= '0;
    end else if (r_state == ST_RUN || w_nextState != r_state || mode_btn || inc_btn) begin
      r_timeout <= '0;
    end else if (tick_1hz) begin
      r_timeout <= r_timeout + TW'(1);
    end
  end

  // Blink restarts low on every set-state entry and is held low in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink <= 1'b0;
    end else if (w_nextState == ST_RUN || w_nextState != r_state) begin
      r_blink <= 1'b0;
    end else if (tick_1hz) begin
      r_blink <= !r_blink;
    end
  end

  // Any return to RUN from a set state restarts the minute at :00.
  assign w_secClr  = (r_state != ST_RUN) && (w_nextState == ST_RUN);
  assign w_secInc  = (r_state == ST_RUN) && tick_1hz;
  assign w_minInc  = w_secCarry || ((r_state == ST_SET_MIN) && w_incEvt);
  // Minute wraps while setting must not carry into the hour.
  assign w_hourInc = ((r_state == ST_RUN) && w_minCarry) ||
                     ((r_state == ST_SET_HOUR) && w_incEvt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chime <= 1'b0;
    end else begin
      r_chime <= (r_state == ST_RUN) && w_minCarry;
    end
  end

  bcd2_counter #(.MAX_VAL(BCD_MAX_MIN_SEC)) u_second (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_secClr),
    .i_inc   (w_secInc),
    .o_value (second),
    .o_carry (w_secCarry)
  );

  bcd2_counter #(.MAX_VAL(BCD_MAX_MIN_SEC)) u_minute (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (1'b0),
    .i_inc   (w_minInc),
    .o_value (minute),
    .o_carry (w_minCarry)
  );

  bcd2_counter #(.MAX_VAL(BCD_MAX_HOUR)) u_hour (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (1'b0),
    .i_inc   (w_hourInc),
    .o_value (hour),
    .o_carry (w_unusedHourCarry)
  );

  assign set_field = r_state;
  assign blink     = r_blink;
  assign chime     = r_chime;

endmodule

// File: tb/tb_timekeep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timekeep_ctrl
// Directed and random stimulus for timekeep_ctrl, checked against a
// time-of-day model kept as plain integers (hours, minutes, seconds).
// ---------------------------------------------------------------------------
module tb_timekeep_ctrl;

  localparam int TIMEOUT = 12;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz;
  logic       mode_btn;
  logic       inc_btn;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic [1:0] set_field;
  logic       blink;
  logic       chime;

  int passCount  = 0;
  int checkCount = 0;

  // Reference model state: mode 0 RUN, 1 SET_HOUR, 2 SET_MIN.
  int mHour, mMin, mSec, mMode, mTimeout;
  bit mBlink, mChime;

  timekeep_ctrl #(.TIMEOUT_TICKS(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .set_field (set_field),
    .blink     (blink),
    .chime     (chime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] toBcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic resetModel();
    mHour = 0; mMin = 0; mSec = 0; mMode = 0; mTimeout = 0;
    mBlink = 0; mChime = 0;
  endtask

  // Advance the model by one clock cycle with the given input pulses.
  task automatic modelStep(input bit t, input bit m, input bit inc);
    bit incEff;
    int total;
    incEff = inc && !m;
    mChime = 0;
    if (mMode == 0) begin
      if (t) begin
        total = mHour * 3600 + mMin * 60 + mSec + 1;
        if (total % 3600 == 0) mChime = 1;
        total = total % 86400;
        mHour = total / 3600;
        mMin  = (total / 60) % 60;
        mSec  = total % 60;
      end
      if (m) begin
        mMode = 1; mTimeout = 0; mBlink = 0;
      end
    end else if (m) begin
      mMode = (mMode == 1) ? 2 : 0;
      mTimeout = 0; mBlink = 0;
      if (mMode == 0) mSec = 0;
    end else begin
      if (incEff) begin
        if (mMode == 1) mHour = (mHour + 1) % 24;
        else            mMin  = (mMin + 1) % 60;
        mTimeout = 0;
      end else if (t) begin
        mTimeout = mTimeout + 1;
      end
      if (t) mBlink = !mBlink;
      if (mTimeout == TIMEOUT) begin
        mMode = 0; mTimeout = 0; mBlink = 0; mSec = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the active edge.
  task automatic applyStimulus(input bit t, input bit m, input bit inc);
    tick_1hz = t; mode_btn = m; inc_btn = inc;
    @(posedge clk);
    modelStep(t, m, inc);
    #1;
    tick_1hz = 0; mode_btn = 0; inc_btn = 0;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    checkValue(tag, {4'h0, hour, minute, second, set_field, blink, chime},
               {4'h0, toBcd(mHour), toBcd(mMin), toBcd(mSec), 2'(mMode), mBlink, mChime});
  endtask

  task automatic stepAndCheck(input bit t, input bit m, input bit inc, input string tag);
    applyStimulus(t, m, inc);
    checkOutput(tag);
  endtask

  // From RUN, set hour:minute via the set modes, then tick up to the seconds.
  task automatic setTime(input int h, input int mi, input int s);
    int nh, nm;
    stepAndCheck(0, 1, 0, "set_enter_hour");
    nh = (h - mHour + 24) % 24;
    repeat (nh) stepAndCheck(0, 0, 1, "set_inc_hour");
    stepAndCheck(0, 1, 0, "set_enter_min");
    nm = (mi - mMin + 60) % 60;
    repeat (nm) stepAndCheck(0, 0, 1, "set_inc_min");
    stepAndCheck(0, 1, 0, "set_exit");
    repeat (s) stepAndCheck(1, 0, 0, "set_tick_sec");
  endtask

  initial begin
    logic [7:0] savedMin, savedSec;
    rst_n = 1'b0; tick_1hz = 0; mode_btn = 0; inc_btn = 0;
    resetModel();
    #12;
    checkValue("reset_state", {4'h0, hour, minute, second, set_field, blink, chime}, 32'h0);
    #1 rst_n = 1'b1;

    // First tick after reset release
    stepAndCheck(1, 0, 0, "first_tick");
    checkValue("first_tick_sec", {24'h0, second}, 32'h01);

    // Midnight rollover with chime
    setTime(23, 59, 58);
    stepAndCheck(1, 0, 0, "roll_235959");
    checkValue("roll_235959_const", {hour, minute, second, 7'h0, chime}, 32'h23595900);
    stepAndCheck(1, 0, 0, "roll_000000");
    checkValue("roll_000000_const", {hour, minute, second, 7'h0, chime}, 32'h00000001);
    stepAndCheck(0, 0, 0, "chime_one_cycle");
    checkValue("chime_low_after", {31'h0, chime}, 32'h0);

    // Set sequence from 10:20:35 to 13:05:00
    setTime(10, 20, 35);
    stepAndCheck(0, 1, 0, "seq_mode1");
    checkValue("seq_field_01", {30'h0, set_field}, 32'h1);
    repeat (3) stepAndCheck(0, 0, 1, "seq_inc_hour");
    stepAndCheck(0, 1, 0, "seq_mode2");
    checkValue("seq_field_10", {30'h0, set_field}, 32'h2);
    repeat (45) stepAndCheck(0, 0, 1, "seq_inc_min");
    stepAndCheck(0, 1, 0, "seq_mode3");
    checkValue("seq_final", {hour, minute, second, 6'h0, set_field}, 32'h13050000);

    // Hour wrap in SET_HOUR; ticks do not move time
    setTime(23, 7, 9);
    stepAndCheck(0, 1, 0, "wrap_enter");
    savedMin = minute; savedSec = second;
    stepAndCheck(0, 0, 1, "wrap_inc");
    checkValue("wrap_hour_00", {24'h0, hour}, 32'h00);
    repeat (10) stepAndCheck(1, 0, 0, "wrap_tick");
    checkValue("wrap_frozen", {16'h0, minute, second}, {16'h0, savedMin, savedSec});
    checkValue("wrap_no_chime", {31'h0, chime}, 32'h0);

    // Collision: mode wins, hour unchanged
    stepAndCheck(0, 1, 1, "collide");
    checkValue("collide_const", {16'h0, hour, 6'h0, set_field}, 32'h00000002);

    // Timeout out of SET_MIN
    repeat (TIMEOUT - 1) stepAndCheck(1, 0, 0, "tmo_tick");
    checkValue("tmo_still_set", {30'h0, set_field}, 32'h2);
    stepAndCheck(1, 0, 0, "tmo_last");
    checkValue("tmo_exit", {22'h0, second, set_field}, 32'h0);

    // Asynchronous reset in SET_MIN with blink high
    stepAndCheck(0, 1, 0, "ar_enter_hour");
    stepAndCheck(0, 1, 0, "ar_enter_min");
    stepAndCheck(1, 0, 0, "ar_blink");
    checkValue("ar_blink_high", {31'h0, blink}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    resetModel();
    checkValue("async_reset", {4'h0, hour, minute, second, set_field, blink, chime}, 32'h0);
    #2 rst_n = 1'b1;
    stepAndCheck(1, 0, 0, "post_reset_tick");

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      stepAndCheck($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 5) == 0, "random");
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
